sequenced_arithmetic_unit: RTL and testbench

Parametrised, multi-cycle successor to the execute-stage ALU. Single-cycle operations complete in one clock. MUL and DIV run as iterative shift-add / restoring-divide sequences of WIDTH steps. Adds a start/busy/done handshake so the pipeline control can stall on long operations, plus overflow and divide-by-zero status. Sits in the execute stage between the register-file read operands and the writeback mux.

---
 rtl/sequenced_arithmetic_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_sequenced_arithmetic_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequenced_arithmetic_unit.sv
//-----------------------------------------------------------------------------
// sequenced_arithmetic_unit
//
// Multi-cycle execute-stage arithmetic unit. Single-cycle operations take one
// EXEC cycle. MUL is an iterative shift-add multiplier and DIV is a restoring
// divider; both run WIDTH iterations plus one finishing cycle. A start/busy/done
// handshake lets pipeline control stall while a long operation is in flight.
//
// Ports
//   clock     : rising-edge clock
//   reset     : synchronous, active-low reset
//   start     : request, sampled only in IDLE
//   operation : ALU opcode (encodings below)
//   opA, opB  : operands
//   opC       : compare operand for SEQ / SNQ
//   shamft    : left shift applied to the arithmetic/logic result
//   busy      : high in EXEC, MULT and DIV
//   done      : one-cycle pulse, result and flags valid from this cycle
//   result    : registered result, held until the next done
//   overflow  : signed overflow of the unshifted ADD/SUB result
//   div_zero  : DIV with opB == 0
//
// Datapath vectors on the ports use [0:WIDTH-1] ordering (bit 0 is the MSB).
// Internally everything is held in [WIDTH-1:0] registers; whole-vector
// assignments preserve the numeric value, so only the bit labels differ.
//-----------------------------------------------------------------------------
module sequenced_arithmetic_unit #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 6,
  parameter int OP_WIDTH    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [OP_WIDTH-1:0]    operation,
  input  logic [0:WIDTH-1]       opA,
  input  logic [0:WIDTH-1]       opB,
  input  logic [0:WIDTH-1]       opC,
  input  logic [SHAMT_WIDTH-1:0] shamft,
  output logic                   busy,
  output logic                   done,
  output logic [0:WIDTH-1]       result,
  output logic                   overflow,
  output logic                   div_zero
);

  // Opcode encodings shared with the rest of the execute stage.
  localparam logic [OP_WIDTH-1:0] ALU_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALU_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] ALU_MUL = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] ALU_DIV = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] ALU_AND = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] ALU_NOR = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] ALU_XOR = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] ALU_SFL = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] ALU_SFR = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] ALU_SLT = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] ALU_SEQ = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] ALU_SNQ = OP_WIDTH'(11);

  // Controller states.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_MULT = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Iteration counter runs 0..WIDTH: WIDTH iteration steps, then one finishing
  // cycle that applies the post-shift and writes the result.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

  logic [2:0]             state;
  logic [OP_WIDTH-1:0]    op_q;
  logic [WIDTH-1:0]       a_q;    // operand A; multiplicand / dividend-quotient
  logic [WIDTH-1:0]       b_q;    // operand B; multiplier / divisor
  logic [WIDTH-1:0]       c_q;
  logic [SHAMT_WIDTH-1:0] sh_q;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       acc;    // multiplier partial product
  logic [WIDTH-1:0]       rem;    // divider partial remainder

  // Single-cycle ALU outputs, consumed in EXEC.
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_dz;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  // Restoring-divide step.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  assign busy = (state == ST_EXEC) || (state == ST_MULT) || (state == ST_DIV);
  assign done = (state == ST_DONE);

  //---------------------------------------------------------------------------
  // Single-cycle operations on the captured operands.
  //---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the case;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_dz  = 1'b0;
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    case (op_q)
      ALU_ADD: begin
        alu_res = sum << sh_q;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff << sh_q;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      // DIV only reaches EXEC with a zero divisor; the all-ones sentinel is
      // reported as-is, without the post-shift.
      ALU_DIV: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      ALU_AND: alu_res = (a_q & b_q) << sh_q;
      ALU_NOR: alu_res = (~(a_q | b_q)) << sh_q;
      ALU_XOR: alu_res = (a_q ^ b_q) << sh_q;
      // Shift amounts at or beyond WIDTH already produce zero for << and >>.
      ALU_SFL: alu_res = (a_q << b_q) << sh_q;
      ALU_SFR: alu_res = (a_q >> b_q) << sh_q;
      ALU_SLT: alu_res = WIDTH'(a_q < b_q) << sh_q;
      ALU_SEQ: alu_res = (c_q == a_q) ? b_q : WIDTH'(1);
      ALU_SNQ: alu_res = (c_q != a_q) ? b_q : WIDTH'(1);
      default: alu_res = '0;
    endcase
  end

  // Shift the next dividend bit into the remainder and try the subtraction.
  // The remainder is always below the divisor, so it fits in WIDTH bits.
  always_comb begin
    div_shift = {rem, a_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
  end

  //---------------------------------------------------------------------------
  // Controller and iterative datapath.
  //---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      sh_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      result   <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= operation;
            a_q  <= opA;
            b_q  <= opB;
            c_q  <= opC;
            sh_q <= shamft;
            cnt  <= '0;
            acc  <= '0;
            rem  <= '0;
            if (operation == ALU_MUL) begin
              state <= ST_MULT;
            end else if ((operation == ALU_DIV) && (opB != '0)) begin
              state <= ST_DIV;
            end else begin
              // Includes DIV by zero, which skips the iterations entirely.
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          result   <= alu_res;
          overflow <= alu_ovf;
          div_zero <= alu_dz;
          state    <= ST_DONE;
        end

        // Shift-add: add the multiplicand for each set multiplier bit, walking
        // the multiplier LSB-first. Only the low WIDTH bits are kept.
        ST_MULT: begin
          if (cnt == CNT_LAST) begin
            result   <= acc << sh_q;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            state    <= ST_DONE;
          end else begin
            if (b_q[0]) begin
              acc <= acc + a_q;
            end
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Restoring divide: a_q shifts the dividend out MSB-first while the
        // quotient bits shift in at the bottom, leaving the quotient in a_q.
        ST_DIV: begin
          if (cnt == CNT_LAST) begin
            result   <= a_q << sh_q;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            state    <= ST_DONE;
          end else begin
            if (!div_trial[WIDTH]) begin
              rem <= div_trial[WIDTH-1:0];
              a_q <= {a_q[WIDTH-2:0], 1'b1};
            end else begin
              rem <= div_shift[WIDTH-1:0];
              a_q <= {a_q[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
          end
        end

        // start is ignored here, so a new request can only be accepted in the
        // IDLE cycle that follows.
        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenced_arithmetic_unit.sv
//-----------------------------------------------------------------------------
// Directed testbench for sequenced_arithmetic_unit (WIDTH=32).
// Latency is counted in cycles from the cycle where start is presented
// (cycle 0): single-cycle ops complete at cycle 2, MUL/DIV at cycle 34.
//-----------------------------------------------------------------------------
module tb_sequenced_arithmetic_unit;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_DIV = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_SFL = 4'd7;
  localparam logic [3:0] ALU_SFR = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;
  localparam logic [3:0] ALU_SEQ = 4'd10;
  localparam logic [3:0] ALU_SNQ = 4'd11;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  operation;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] opC;
  logic [5:0]  shamft;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  sequenced_arithmetic_unit #(
    .WIDTH       (32),
    .SHAMT_WIDTH (6),
    .OP_WIDTH    (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .opA       (opA),
    .opB       (opB),
    .opC       (opC),
    .shamft    (shamft),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one request from an IDLE cycle and follow it to done. Inputs are
  // scrambled after acceptance to confirm they were captured. If poke > 0, an
  // ADD start is raised at that cycle while the unit is busy.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [5:0] sh,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_dz,
                        input int poke);
    int lat;
    int busy_cnt;
    operation = op;
    opA       = a;
    opB       = b;
    opC       = c;
    shamft    = sh;
    start     = 1'b1;
    lat       = -1;
    busy_cnt  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        start  = 1'b0;
        opA    = ~a;
        opB    = ~b;
        opC    = ~c;
        shamft = ~sh;
      end
      if (k == poke) begin
        start     = 1'b1;
        operation = ALU_ADD;
      end
      if (k == poke + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"},  lat,       exp_lat);
    check({tag, "_busy_cyc"}, busy_cnt,  exp_lat - 1);
    check({tag, "_result"},   result,    exp_res);
    check({tag, "_overflow"}, overflow,  exp_ovf);
    check({tag, "_div_zero"}, div_zero,  exp_dz);
    check({tag, "_busy_at_done"}, busy,  1'b0);
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, done,    1'b0);
    check({tag, "_idle_after"}, busy,    1'b0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int dones;

    // Reset held for two cycles with a pending ADD request.
    reset     = 1'b0;
    start     = 1'b1;
    operation = ALU_ADD;
    opA       = 32'd1;
    opB       = 32'd2;
    opC       = 32'd0;
    shamft    = 6'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("rst_busy",     busy,     1'b0);
      check("rst_done",     done,     1'b0);
      check("rst_result",   result,   32'h0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_div_zero", div_zero, 1'b0);
    end
    start = 1'b0;
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (done || busy) dones++;
    end
    check("rst_no_spurious", dones, 0);

    // ADD / SUB with overflow handling; requests issued back to back.
    run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 6'd0,
           2, 32'h8000_0000, 1'b1, 1'b0, 0);
    run_op("sub_sh2", ALU_SUB, 32'd5, 32'd3, 32'h0, 6'd2,
           2, 32'd8, 1'b0, 1'b0, 0);
    run_op("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h1, 32'h0, 6'd0,
           2, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);

    // MUL with an ignored ADD request in the middle.
    run_op("mul", ALU_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0, 6'd0,
           34, 32'h0002_0001, 1'b0, 1'b0, 5);
    run_op("mul_sh4", ALU_MUL, 32'd3, 32'd5, 32'h0, 6'd4,
           34, 32'h0000_00F0, 1'b0, 1'b0, 0);

    // DIV, including divide-by-zero and flag clearing afterwards.
    run_op("div", ALU_DIV, 32'd100, 32'd7, 32'h0, 6'd0,
           34, 32'd14, 1'b0, 1'b0, 0);
    run_op("div_max", ALU_DIV, 32'hFFFF_FFFF, 32'd1, 32'h0, 6'd0,
           34, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op("div_zero", ALU_DIV, 32'd100, 32'd0, 32'h0, 6'd0,
           2, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);

    // Compare / select and shifts.
    run_op("seq", ALU_SEQ, 32'd9, 32'd42, 32'd9, 6'd3,
           2, 32'd42, 1'b0, 1'b0, 0);
    run_op("snq", ALU_SNQ, 32'd9, 32'd42, 32'd9, 6'd3,
           2, 32'd1, 1'b0, 1'b0, 0);
    run_op("sfl_big", ALU_SFL, 32'd1, 32'd40, 32'h0, 6'd0,
           2, 32'h0, 1'b0, 1'b0, 0);
    run_op("sfr", ALU_SFR, 32'h8000_0000, 32'd4, 32'h0, 6'd1,
           2, 32'h1000_0000, 1'b0, 1'b0, 0);
    run_op("slt", ALU_SLT, 32'd3, 32'd5, 32'h0, 6'd31,
           2, 32'h8000_0000, 1'b0, 1'b0, 0);
    run_op("xor", ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 6'd0,
           2, 32'hF00F_F00F, 1'b0, 1'b0, 0);
    run_op("nor_shbig", ALU_NOR, 32'h0, 32'h0, 32'h0, 6'd40,
           2, 32'h0, 1'b0, 1'b0, 0);
    run_op("unknown", 4'd15, 32'h1234_5678, 32'h1, 32'h0, 6'd0,
           2, 32'h0, 1'b0, 1'b0, 0);

    // DIV aborted by reset at iteration 10: no done, outputs cleared.
    operation = ALU_DIV;
    opA       = 32'd100;
    opB       = 32'd7;
    shamft    = 6'd0;
    start     = 1'b1;
    dones     = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      if (k == 1) start = 1'b0;
      if (done) dones++;
    end
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b0;
    @(posedge clock); #1;
    check("abort_busy",   busy,   1'b0);
    check("abort_done",   done,   1'b0);
    check("abort_result", result, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);

    run_op("and_after_abort", ALU_AND, 32'h0000_00F0, 32'h0000_003C, 32'h0, 6'd0,
           2, 32'h0000_0030, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
